// File: rtl/irq_ctrl_if.sv
// Bus bundle between CP0-side logic / devices and the external interrupt controller.
// The master side drives requests and strobes; the controller (slave) drives status.
interface irq_ctrl_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] irq_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic [N_IRQ-1:0] pend_clr;
    logic             ir_taken;
    logic             eret;
    logic             ir_out;
    logic [ID_W-1:0]  ir_id;
    logic             busy;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;

    modport master (
        output irq_in, mask_we, mask_wdata, pend_clr, ir_taken, eret,
        input  ir_out, ir_id, busy, pending, mask
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, pend_clr, ir_taken, eret,
        output ir_out, ir_id, busy, pending, mask
    );
endinterface

// File: rtl/irq_ctrl.sv
// External interrupt controller: edge-latched pending, mask, fixed priority,
// and a request/service handshake that holds ir_out low until ERET retires.
module irq_ctrl #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic          clk,
    input  logic          rst,
    irq_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] prev_q;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             irout_q, busy_q;

    logic [N_IRQ-1:0] edges;
    logic [N_IRQ-1:0] eligible;
    logic [N_IRQ-1:0] take_clr;
    logic [ID_W-1:0]  sel;
    logic             take;

    assign edges    = bus.irq_in & ~prev_q;
    assign eligible = pend_q & mask_q;
    assign take     = (state_q == REQ) && bus.ir_taken;

    // Scan downward so the lowest set index ends up winning.
    always_comb begin
        sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) sel = ID_W'(i);
        end
    end

    always_comb begin
        take_clr = '0;
        if (take) take_clr[id_q] = 1'b1;
        pend_d = (pend_q & ~(bus.pend_clr | take_clr)) | edges;
        mask_d = bus.mask_we ? bus.mask_wdata : mask_q;
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (eligible != '0) begin
                    id_d    = sel;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.ir_taken)
                    state_d = SERVICE;
                else if (!mask_q[id_q] || !pend_q[id_q])
                    state_d = IDLE;
            end
            SERVICE: begin
                if (bus.eret) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            id_q    <= '0;
            irout_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= bus.irq_in;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            id_q    <= id_d;
            irout_q <= (state_d == REQ);
            busy_q  <= (state_d == SERVICE);
        end
    end

    assign bus.ir_out  = irout_q;
    assign bus.ir_id   = id_q;
    assign bus.busy    = busy_q;
    assign bus.pending = pend_q;
    assign bus.mask    = mask_q;
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed plus randomized bench for irq_ctrl against a behavioural model
// of the interrupt request/service rules.
module tb_irq_ctrl;
    localparam int N = 8;
    localparam int W = 3;
    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_SERV = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    irq_ctrl_if #(.N_IRQ(N), .ID_W(W)) bus ();

    irq_ctrl #(.N_IRQ(N), .ID_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [N-1:0] irq = '0, wd = '0, clr = '0;
    logic         we = 0, tk = 0, er = 0, r = 0;

    logic [N-1:0] m_prev, m_pend, m_mask;
    int           m_id, m_st;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clock();
        logic [N-1:0] ed, np;
        int nst, nid;
        bit found;
        if (r) begin
            m_prev = '0; m_pend = '0; m_mask = '0; m_id = 0; m_st = S_IDLE;
            return;
        end
        ed  = irq & ~m_prev;
        np  = m_pend;
        nst = m_st;
        nid = m_id;
        for (int i = 0; i < N; i++) begin
            if (ed[i]) np[i] = 1'b1;
            else if (clr[i] || (m_st == S_REQ && tk && i == m_id)) np[i] = 1'b0;
        end
        if (m_st == S_IDLE) begin
            found = 0;
            for (int i = 0; i < N; i++)
                if (!found && m_pend[i] && m_mask[i]) begin
                    found = 1; nid = i;
                end
            if (found) nst = S_REQ;
        end else if (m_st == S_REQ) begin
            if (tk) nst = S_SERV;
            else if (!(m_mask[m_id] && m_pend[m_id])) nst = S_IDLE;
        end else if (er) begin
            nst = S_IDLE;
        end
        if (we) m_mask = wd;
        m_prev = irq;
        m_pend = np;
        m_st   = nst;
        m_id   = nid;
    endtask

    task automatic step();
        rst            = r;
        bus.irq_in     = irq;
        bus.mask_we    = we;
        bus.mask_wdata = wd;
        bus.pend_clr   = clr;
        bus.ir_taken   = tk;
        bus.eret       = er;
        @(posedge clk);
        model_clock();
        #1;
        chk("ir_out",  32'(bus.ir_out),  32'(m_st == S_REQ));
        chk("busy",    32'(bus.busy),    32'(m_st == S_SERV));
        chk("ir_id",   32'(bus.ir_id),   32'(m_id));
        chk("pending", 32'(bus.pending), 32'(m_pend));
        chk("mask",    32'(bus.mask),    32'(m_mask));
        we = 0; clr = '0; tk = 0; er = 0;
    endtask

    initial begin
        int rises;
        logic last;
        m_prev = '0; m_pend = '0; m_mask = '0; m_id = 0; m_st = S_IDLE;

        // 1: basic request / take
        r = 1; step(); r = 0;
        chk("rst_ir_out", 32'(bus.ir_out), 0);
        chk("rst_pending", 32'(bus.pending), 0);
        chk("rst_mask", 32'(bus.mask), 0);
        we = 1; wd = 8'hFF; step();
        irq = 8'h08; step();
        chk("t1_pend", 32'(bus.pending), 32'h08);
        chk("t1_irout0", 32'(bus.ir_out), 0);
        step();
        chk("t1_irout", 32'(bus.ir_out), 1);
        chk("t1_id", 32'(bus.ir_id), 3);
        step(); step(); step();
        irq = '0; step();
        chk("t1_hold", 32'(bus.ir_out), 1);
        tk = 1; step();
        chk("t1_taken_pend", 32'(bus.pending), 0);
        chk("t1_taken_busy", 32'(bus.busy), 1);
        chk("t1_taken_irout", 32'(bus.ir_out), 0);
        er = 1; step();

        // 2: priority
        irq = 8'h24; step(); step();
        chk("t2_id2", 32'(bus.ir_id), 2);
        chk("t2_irout", 32'(bus.ir_out), 1);
        irq = '0; tk = 1; step();
        er = 1; step();
        chk("t2_gap", 32'(bus.ir_out), 0);
        chk("t2_gap_busy", 32'(bus.busy), 0);
        step();
        chk("t2_id5", 32'(bus.ir_id), 5);
        chk("t2_irout5", 32'(bus.ir_out), 1);
        tk = 1; step();
        er = 1; step();

        // 3: masking
        we = 1; wd = 8'h00; step();
        irq = 8'h02; step();
        chk("t3_pend", 32'(bus.pending), 32'h02);
        step(); irq = '0;
        chk("t3_masked", 32'(bus.ir_out), 0);
        we = 1; wd = 8'h02; step();
        chk("t3_w1", 32'(bus.ir_out), 0);
        step();
        chk("t3_irout", 32'(bus.ir_out), 1);
        chk("t3_id", 32'(bus.ir_id), 1);
        we = 1; wd = 8'h00; step();
        step();
        chk("t3_drop", 32'(bus.ir_out), 0);
        chk("t3_pend_kept", 32'(bus.pending), 32'h02);
        chk("t3_id_hold", 32'(bus.ir_id), 1);

        // 4: set beats clear
        clr = 8'h02; step();
        irq = 8'h10; clr = 8'h10; step();
        chk("t4_set_wins", 32'(bus.pending[4]), 1);
        clr = 8'h10; step();
        chk("t4_clear", 32'(bus.pending[4]), 0);
        irq = '0; step();

        // 5: stray strobes, held level
        er = 1; step();
        chk("t5_eret_idle", 32'(bus.ir_out | bus.busy), 0);
        we = 1; wd = 8'hFF; step();
        irq = 8'h40; step(); step();
        tk = 1; step();
        irq = '0; tk = 1; step();
        chk("t5_taken_serv", 32'(bus.busy), 1);
        chk("t5_taken_pend", 32'(bus.pending), 0);
        er = 1; step();
        irq = 8'h01; rises = 0; last = bus.ir_out;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.ir_out && !last) rises++;
            last = bus.ir_out;
        end
        chk("t5_one_req", 32'(rises), 1);
        irq = '0; tk = 1; step();
        er = 1; step();

        // 6: reset in service
        irq = 8'h01; step(); step();
        tk = 1; irq = '0; step();
        irq = 8'h81; step();
        chk("t6_pend81", 32'(bus.pending), 32'h81);
        chk("t6_busy", 32'(bus.busy), 1);
        r = 1; step(); r = 0;
        chk("t6_pend0", 32'(bus.pending), 0);
        chk("t6_busy0", 32'(bus.busy), 0);
        chk("t6_mask0", 32'(bus.mask), 0);
        chk("t6_irout0", 32'(bus.ir_out), 0);
        irq = '0; step();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            we  = ($urandom_range(0, 15) == 0);
            wd  = 8'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : '0;
            tk  = ($urandom_range(0, 3) == 0);
            er  = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 99) == 0);
            step();
            r = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
